perf_fpga_stream_driver: RTL and testbench

Host-side counterpart of the single perf engine. It issues one read or write request to the engine and supplies the far end of that engine's streams. For reads it sources the beats the engine consumes. For writes it sinks and checks the beats the engine produces. It measures request latency and sits between the vFPGA control registers and one engine instance in the perf example.

---
 rtl/perf_pkg.sv | 10 +
 rtl/lynx_axi4sr.sv | 14 +
 rtl/perf_stream_checker.sv | 32 +++
 rtl/perf_fpga_stream_driver.sv | 102 ++++++++++
 tb/tb_perf_fpga_stream_driver.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/perf_pkg.sv
// perf_pkg: shared request/state types, counter width and saturating increment
// for the perf engine host driver.
package perf_pkg;
  localparam int PERF_CNT_BITS = 64;
  typedef enum logic [1:0] {NONE = 2'b00, RD = 2'b01, WR = 2'b10} perf_req_t;
  typedef enum logic [1:0] {IDLE, ISSUE, RUN, DONE} drv_state_t;
  function automatic logic [PERF_CNT_BITS-1:0] sat_inc(input logic [PERF_CNT_BITS-1:0] v);
    return &v ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/lynx_axi4sr.sv
// AXI4SR: lynxTypes-compatible AXI4 stream with routing id.
interface AXI4SR #(
  parameter int AXI4S_DATA_BITS = 512,
  parameter int AXI4S_ID_BITS = 6
);
  logic tvalid;
  logic tready;
  logic tlast;
  logic [AXI4S_DATA_BITS-1:0] tdata;
  logic [AXI4S_DATA_BITS/8-1:0] tkeep;
  logic [AXI4S_ID_BITS-1:0] tid;
  modport m (output tvalid, tdata, tkeep, tid, tlast, input tready);
  modport s (input tvalid, tdata, tkeep, tid, tlast, output tready);
endinterface

// File: rtl/perf_stream_checker.sv
// perf_stream_checker: expected-beat down-counter and tdata comparator with a
// saturating error count; err_nxt already includes the beat in the current cycle.
module perf_stream_checker import perf_pkg::*; #(
  parameter int DATA_BITS = 512
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     clr,
  input  logic [PERF_CNT_BITS-1:0] n_load,
  input  logic                     hs,
  input  logic [DATA_BITS-1:0]     tdata,
  output logic [31:0]              err_nxt
);
  logic [PERF_CNT_BITS-1:0] exp_q, exp_d;
  logic [31:0] err_q, err_d;
  logic miss;
  always_comb begin
    miss = hs && (tdata != DATA_BITS'(exp_q));
    exp_d = clr ? n_load : hs ? exp_q - 64'd1 : exp_q;
    err_d = clr ? '0 : (miss && !(&err_q)) ? err_q + 32'd1 : err_q;
    err_nxt = err_d;
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      exp_q <= '0;
      err_q <= '0;
    end else begin
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end
endmodule

// File: rtl/perf_fpga_stream_driver.sv
// perf_fpga_stream_driver: issues one perf engine request, sources/sinks its streams
// and times it. PERF_DRV_DATA_CHECK_EN builds the write-data checker; else err_cnt=0.
module perf_fpga_stream_driver import perf_pkg::*; #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
  parameter int          AXI_DATA_BITS  = 512
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     start,
  input  logic [1:0]               cmd_type,
  input  logic [PERF_CNT_BITS-1:0] cmd_beats,
  output logic [1:0]               req_type,
  output logic [PERF_CNT_BITS-1:0] n_beats,
  input  logic                     eng_busy,
  input  logic                     eng_done,
  AXI4SR.m                         axis_gen,
  AXI4SR.s                         axis_chk,
  output logic                     idle,
  output logic                     complete,
  output logic                     timeout,
  output logic [PERF_CNT_BITS-1:0] cycles,
  output logic [PERF_CNT_BITS-1:0] beats,
  output logic [31:0]              err_cnt
);
  drv_state_t state_q, state_d;
  perf_req_t typ_q, typ_d;
  logic [PERF_CNT_BITS-1:0] rem_q, rem_d, cnt_q, cnt_d, bcnt_q, bcnt_d;
  logic [PERF_CNT_BITS-1:0] cycles_q, cycles_d, beats_q, beats_d;
  logic [31:0] err_q, err_d, err_nxt;
  logic timeout_q, timeout_d, accept, rd_run, wr_run, gen_v, hs, tmo, fin, unused_ok;
  always_comb begin
    accept = state_q == IDLE && start && (cmd_type == RD || cmd_type == WR) && !eng_busy;
    rd_run = state_q == RUN && typ_q == RD;
    wr_run = state_q == RUN && typ_q == WR;
    gen_v = rd_run && rem_q != '0;
    hs = (gen_v && axis_gen.tready) || (wr_run && axis_chk.tvalid);
    tmo = state_q == RUN && cnt_q >= 64'(TIMEOUT_CYCLES);
    // eng_done is honoured in ISSUE as well, so a zero-latency engine cannot hang us
    fin = (state_q == ISSUE || state_q == RUN) && (eng_done || tmo);
    state_d = fin ? DONE : accept ? ISSUE : state_q == ISSUE ? RUN : state_q == DONE ? IDLE : state_q;
    typ_d = accept ? perf_req_t'(cmd_type) : typ_q;
    rem_d = accept ? cmd_beats : (gen_v && axis_gen.tready) ? rem_q - 64'd1 : rem_q;
    cnt_d = accept ? '0 : (state_q == ISSUE || state_q == RUN) ? sat_inc(cnt_q) : cnt_q;
    bcnt_d = accept ? '0 : bcnt_q + {63'd0, hs};
    // results include the finishing cycle and any beat that lands with eng_done
    cycles_d = accept ? '0 : fin ? sat_inc(cnt_q) : cycles_q;
    beats_d = accept ? '0 : fin ? bcnt_q + {63'd0, hs} : beats_q;
    err_d = accept ? '0 : fin ? err_nxt : err_q;
    timeout_d = !accept && (timeout_q || tmo);
  end
`ifdef PERF_DRV_DATA_CHECK_EN
  perf_stream_checker #(.DATA_BITS(AXI_DATA_BITS)) u_chk (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (accept),
    .n_load  (cmd_beats),
    .hs      (wr_run && axis_chk.tvalid),
    .tdata   (axis_chk.tdata),
    .err_nxt (err_nxt)
  );
`else
  assign err_nxt = '0;
`endif
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      typ_q <= NONE;
      rem_q <= '0;
      cnt_q <= '0;
      bcnt_q <= '0;
      cycles_q <= '0;
      beats_q <= '0;
      err_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      typ_q <= typ_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      bcnt_q <= bcnt_d;
      cycles_q <= cycles_d;
      beats_q <= beats_d;
      err_q <= err_d;
      timeout_q <= timeout_d;
    end
  end
  assign req_type = state_q == ISSUE ? typ_q : NONE;
  assign n_beats = state_q == ISSUE ? rem_q : '0;
  assign axis_gen.tvalid = gen_v;
  assign axis_gen.tdata = AXI_DATA_BITS'(rem_q);
  assign axis_gen.tkeep = {(AXI_DATA_BITS/8){gen_v}};
  assign axis_gen.tid = '0;
  assign axis_gen.tlast = gen_v && rem_q == 64'd1;
  assign axis_chk.tready = wr_run;
  assign idle = state_q == IDLE;
  assign complete = state_q == DONE;
  assign timeout = timeout_q;
  assign cycles = cycles_q;
  assign beats = beats_q;
  assign err_cnt = err_q;
  assign unused_ok = ^{axis_chk.tkeep, axis_chk.tid, axis_chk.tlast, axis_chk.tdata};
endmodule

// File: tb/tb_perf_fpga_stream_driver.sv
// tb_perf_fpga_stream_driver: scoreboard bench with a behavioural perf engine on
// both streams; run results and read beats are queued at issue, checked on output.
`timescale 1ns/1ps
module tb_perf_fpga_stream_driver;
  import perf_pkg::*;
  localparam int DW = 128;
  typedef struct {
    logic [63:0] cyc;
    logic [63:0] bts;
    logic [31:0] err;
    logic        tmo;
  } res_t;
  logic aclk = 1'b0, aresetn = 1'b0, start = 1'b0;
  logic [1:0] cmd_type = 2'b00;
  logic [63:0] cmd_beats = '0;
  logic [1:0] req_type;
  logic [63:0] n_beats, cycles, beats, e_rem;
  logic eng_busy, eng_done, idle, complete, timeout, e_wr;
  logic [31:0] err_cnt;
  logic hold_done = 1'b0, abort = 1'b0, corrupt = 1'b0;
  int checks = 0, failures = 0, req_seen = 0, wr_hs = 0, cyc_ctr = 0, iss_t = 0;
  res_t res_q[$];
  logic [63:0] rd_q[$];
  AXI4SR #(.AXI4S_DATA_BITS(DW)) axis_gen ();
  AXI4SR #(.AXI4S_DATA_BITS(DW)) axis_chk ();

  always #5 aclk = ~aclk;

  perf_fpga_stream_driver #(.TIMEOUT_CYCLES(32'd16), .AXI_DATA_BITS(DW)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .cmd_type(cmd_type), .cmd_beats(cmd_beats),
    .req_type(req_type), .n_beats(n_beats), .eng_busy(eng_busy), .eng_done(eng_done),
    .axis_gen(axis_gen), .axis_chk(axis_chk), .idle(idle), .complete(complete),
    .timeout(timeout), .cycles(cycles), .beats(beats), .err_cnt(err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // engine model: always ready on the read stream, streams N..1 on writes, done one cycle after the last beat
  assign axis_gen.tready = 1'b1;
  assign axis_chk.tvalid = eng_busy && e_wr && e_rem != 0;
  assign axis_chk.tdata = DW'((corrupt && e_rem == 64'd3) ? 64'd7 : e_rem);
  assign axis_chk.tkeep = '1;
  assign axis_chk.tid = '0;
  assign axis_chk.tlast = e_rem == 64'd1;
  always @(posedge aclk) begin
    if (!aresetn || abort) begin
      eng_busy <= 1'b0;
      eng_done <= 1'b0;
      e_rem <= '0;
      e_wr <= 1'b0;
    end else begin
      eng_done <= 1'b0;
      if (!eng_busy && req_type != 2'b00) begin
        eng_busy <= 1'b1;
        e_rem <= n_beats;
        e_wr <= req_type == WR;
      end else if (eng_busy) begin
        if ((axis_gen.tvalid && !e_wr) || (axis_chk.tvalid && axis_chk.tready)) e_rem <= e_rem - 64'd1;
        else if (e_rem == 0 && !hold_done) begin
          eng_done <= 1'b1;
          eng_busy <= 1'b0;
        end
      end
    end
  end

  always @(negedge aclk) begin : mon
    logic [63:0] e;
    res_t r;
    cyc_ctr++;
    if (aresetn) begin
      if (req_type != 2'b00) begin
        req_seen++;
        iss_t = cyc_ctr;
      end
      if (axis_chk.tvalid && axis_chk.tready) wr_hs++;
      if (axis_gen.tvalid) begin
        if (rd_q.size() == 0) check("rd_extra_beat", 1, 0);
        else begin
          e = rd_q.pop_front();
          check("rd_tdata", axis_gen.tdata[63:0], e);
          check("rd_tdata_hi", axis_gen.tdata[DW-1:64], 0);
          check("rd_tlast", axis_gen.tlast, e == 64'd1);
          check("rd_tkeep", &axis_gen.tkeep, 1);
        end
      end
      if (complete) begin
        if (res_q.size() == 0) check("unexpected_complete", 1, 0);
        else begin
          r = res_q.pop_front();
          check("res_cycles", cycles, r.cyc);
          check("res_beats", beats, r.bts);
          check("res_err_cnt", err_cnt, r.err);
          check("res_timeout", timeout, r.tmo);
          check("complete_lat", cyc_ctr - iss_t, r.cyc);
        end
      end
    end
  end

  task automatic expect_res(input logic [63:0] c, input logic [63:0] b, input logic [31:0] er, input logic t);
    res_t r;
    r.cyc = c;
    r.bts = b;
    r.err = er;
    r.tmo = t;
    res_q.push_back(r);
  endtask

  task automatic issue(input logic [1:0] t, input logic [63:0] n);
    @(negedge aclk);
    start = 1'b1;
    cmd_type = t;
    cmd_beats = n;
    @(negedge aclk);
    start = 1'b0;
    cmd_type = 2'b00;
    cmd_beats = '0;
    check("req_type", req_type, t);
    check("n_beats", n_beats, n);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!idle && n < budget) begin
      @(negedge aclk);
      n++;
    end
    check("idle_in_budget", idle, 1);
    check("res_drained", res_q.size(), 0);
    check("rd_drained", rd_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int w0, n, r0;
    repeat (3) @(negedge aclk);
    check("rst_idle", idle, 1);
    check("rst_complete", complete, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cycles", cycles, 0);
    check("rst_beats", beats, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_req_type", req_type, 0);
    check("rst_gen_tvalid", axis_gen.tvalid, 0);
    check("rst_chk_tready", axis_chk.tready, 0);
    aresetn = 1'b1;
    for (int i = 4; i > 0; i--) rd_q.push_back(64'(i));
    expect_res(7, 4, 0, 0);
    issue(RD, 4);
    wait_idle(50);
    repeat (2) @(negedge aclk);
    check("hold_cycles", cycles, 7);
    check("hold_beats", beats, 4);
    w0 = wr_hs;
    expect_res(8, 5, 0, 0);
    issue(WR, 5);
    wait_idle(50);
    check("wr_handshakes", wr_hs - w0, 5);
    corrupt = 1'b1;
`ifdef PERF_DRV_DATA_CHECK_EN
    expect_res(8, 5, 1, 0);
`else
    expect_res(8, 5, 0, 0);
`endif
    issue(WR, 5);
    wait_idle(50);
    corrupt = 1'b0;
    expect_res(3, 0, 0, 0);
    issue(RD, 0);
    wait_idle(50);
    hold_done = 1'b1;
    rd_q.push_back(2);
    rd_q.push_back(1);
    expect_res(17, 2, 0, 1);
    issue(RD, 2);
    wait_idle(60);
    r0 = req_seen;
    @(negedge aclk);
    start = 1'b1;
    cmd_type = RD;
    cmd_beats = 64'd1;
    @(negedge aclk);
    start = 1'b0;
    repeat (3) @(negedge aclk);
    check("busy_refused_idle", idle, 1);
    check("busy_refused_req", req_seen - r0, 0);
    check("timeout_sticky", timeout, 1);
    hold_done = 1'b0;
    abort = 1'b1;
    @(negedge aclk);
    abort = 1'b0;
    rd_q.push_back(1);
    expect_res(4, 1, 0, 0);
    issue(RD, 1);
    check("timeout_cleared", timeout, 0);
    check("cycles_cleared", cycles, 0);
    wait_idle(50);
    r0 = req_seen;
    expect_res(13, 10, 0, 0);
    issue(WR, 10);
    start = 1'b1;
    cmd_type = RD;
    cmd_beats = 64'd3;
    @(negedge aclk);
    start = 1'b0;
    repeat (2) @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    cmd_type = 2'b00;
    cmd_beats = '0;
    wait_idle(50);
    check("busy_start_ignored", req_seen - r0, 1);
    w0 = wr_hs;
    n = 0;
    issue(WR, 100);
    while (wr_hs - w0 < 10 && n < 40) begin
      @(negedge aclk);
      n++;
    end
    check("ten_beats_seen", wr_hs - w0 >= 10, 1);
    aresetn = 1'b0;
    @(negedge aclk);
    check("mid_rst_idle", idle, 1);
    check("mid_rst_complete", complete, 0);
    check("mid_rst_cycles", cycles, 0);
    check("mid_rst_beats", beats, 0);
    check("mid_rst_timeout", timeout, 0);
    check("mid_rst_chk_tready", axis_chk.tready, 0);
    check("mid_rst_req_type", req_type, 0);
    aresetn = 1'b1;
    for (int i = 3; i > 0; i--) rd_q.push_back(64'(i));
    expect_res(6, 3, 0, 0);
    issue(RD, 3);
    wait_idle(50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
